// File: rtl/store_fifo_port.sv
// store_fifo_port: snoops data-memory stores in an address window and queues them.
// Optional saturating drop counter enabled by defining STOREQ_DROPCNT_EN.
module store_fifo_port #(
    parameter int          DEPTH = 8,
    parameter logic [31:0] BASE  = 32'h0000_0100,
    parameter logic [31:0] MASK  = 32'hFFFF_FF00
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [31:0]              dataadr,
    input  logic [31:0]              writedata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [7:0]               out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_ovf,
    output logic [7:0]               dropcnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [39:0]   mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, full, push_ok, drop;
    logic [39:0]   head;

    assign push    = memwrite & ((dataadr & MASK) == BASE);
    assign full    = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop     = out_valid & out_ready;
    // A full queue still accepts a store when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    assign head     = mem_q[rp_q];
    assign out_data = out_valid ? head[31:0] : 32'h0;
    assign out_addr = out_valid ? head[39:32] : 8'h0;
    assign count    = count_q;
    assign overflow = ovf_q;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_ok) wp_d = wp_q + AW'(1);
        if (pop)     rp_d = rp_q + AW'(1);
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push_ok) count_d = count_q - CW'(1);
        if (drop)           ovf_d = 1'b1;
        else if (clear_ovf) ovf_d = 1'b0;
    end

    // Control state register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q] <= {dataadr[7:0], writedata};
    end

`ifdef STOREQ_DROPCNT_EN
    logic [7:0] dropcnt_q, dropcnt_d;

    // Saturating drop counter; a drop coinciding with a clear counts as one.
    always_comb begin
        dropcnt_d = dropcnt_q;
        if (clear_ovf)                       dropcnt_d = drop ? 8'd1 : 8'd0;
        else if (drop && dropcnt_q != 8'hFF) dropcnt_d = dropcnt_q + 8'd1;
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) dropcnt_q <= 8'h00;
        else       dropcnt_q <= dropcnt_d;
    end

    assign dropcnt = dropcnt_q;
`else
    assign dropcnt = 8'h00;
`endif

endmodule

// File: tb/tb_store_fifo_port.sv
// Testbench for store_fifo_port: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_store_fifo_port;
    localparam int DEPTH = 8;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] MASK = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [7:0]  out_addr;
    logic [3:0]  count;
    logic        overflow;
    logic        clear_ovf = 1'b0;
    logic [7:0]  dropcnt;

    int n_checks = 0;
    int n_fail = 0;

    logic [39:0] mq[$];
    logic        m_ovf;
    int          m_dc;

    store_fifo_port #(.DEPTH(DEPTH), .BASE(BASE), .MASK(MASK)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .count(count),
        .overflow(overflow), .clear_ovf(clear_ovf), .dropcnt(dropcnt)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_dc = 0;
    endtask

    // Drive one cycle of inputs from a negedge, advance the model at the
    // posedge, and return at the following negedge.
    task automatic tick(input logic mw, input logic [31:0] adr,
                        input logic [31:0] wd, input logic rdy,
                        input logic clr);
        bit hit, pop, was_full, drp;
        memwrite = mw; dataadr = adr; writedata = wd;
        out_ready = rdy; clear_ovf = clr;
        @(posedge clk);
        hit = mw && ((adr & MASK) == BASE);
        pop = (mq.size() != 0) && rdy;
        was_full = (mq.size() == DEPTH);
        drp = hit && was_full && !pop;
        if (pop) void'(mq.pop_front());
        if (hit && !drp) mq.push_back({adr[7:0], wd});
        if (drp) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
`ifdef STOREQ_DROPCNT_EN
        if (clr) m_dc = drp ? 1 : 0;
        else if (drp && m_dc < 255) m_dc = m_dc + 1;
`endif
        @(negedge clk);
        memwrite = 1'b0; clear_ovf = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        tick(1'b0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        memwrite = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 4'd0 || out_data !== 32'h0 ||
            out_addr !== 8'h0 || overflow !== 1'b0 || dropcnt !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b count=%0d data=%h addr=%h ovf=%b dc=%0d want all zero",
                     out_valid, count, out_data, out_addr, overflow, dropcnt);
        end
    endtask

    task automatic test_single_capture();
        do_reset();
        tick(1'b1, 32'h104, 32'hDEADBEEF, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF ||
                out_addr !== 8'h04 || count !== 4'd1) begin
                n_fail++;
                $display("FAIL single_capture[%0d]: valid=%b data=%h addr=%h count=%0d want 1 deadbeef 04 1",
                         i, out_valid, out_data, out_addr, count);
            end
            idle(1'b0);
        end
    endtask

    task automatic test_window_filter();
        logic [31:0] miss[3];
        miss[0] = 32'h54; miss[1] = 32'h200; miss[2] = 32'h0FC;
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, miss[i], 32'h1234 + i, 1'b0, 1'b0);
        n_checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL window_miss: count=%0d valid=%b want 0 0", count, out_valid);
        end
        tick(1'b1, 32'h1FC, 32'hCAFE0001, 1'b0, 1'b0);
        n_checks++;
        if (count !== 4'd1 || out_addr !== 8'hFC || out_data !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL window_hit: count=%0d addr=%h data=%h want 1 fc cafe0001",
                     count, out_addr, out_data);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 10; i++) tick(1'b1, 32'h100 + i, i, 1'b0, 1'b0);
        n_checks++;
`ifdef STOREQ_DROPCNT_EN
        if (count !== 4'd8 || overflow !== 1'b1 || dropcnt !== 8'd2) begin
`else
        if (count !== 4'd8 || overflow !== 1'b1 || dropcnt !== 8'd0) begin
`endif
            n_fail++;
            $display("FAIL fill_overflow: count=%0d ovf=%b dc=%0d want 8 1 %0d",
                     count, overflow, dropcnt, m_dc);
        end
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== i) begin
                n_fail++;
                $display("FAIL drain[%0d]: valid=%b data=%h want 1 %h", i, out_valid, out_data, i);
            end
            idle(1'b1);
        end
        n_checks++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL drain_empty: valid=%b count=%0d want 0 0", out_valid, count);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 32'h120 + i, 32'h10 + i, 1'b0, 1'b0);
        tick(1'b1, 32'h1A5, 32'hA5, 1'b1, 1'b0);
        n_checks++;
        if (count !== 4'd8 || overflow !== 1'b0 || out_data !== 32'h11) begin
            n_fail++;
            $display("FAIL full_push_pop: count=%0d ovf=%b head=%h want 8 0 11",
                     count, overflow, out_data);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || {out_addr, out_data} !== mq[0]) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: got %h_%h want %h", i, out_addr, out_data, mq[0]);
            end
            if (i == 7) begin
                n_checks++;
                if (out_data !== 32'hA5 || out_addr !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL last_a5: got %h_%h want a5_000000a5", out_addr, out_data);
                end
            end
            idle(1'b1);
        end
    endtask

    task automatic test_clear_priority();
        do_reset();
        for (int i = 0; i < 9; i++) tick(1'b1, 32'h100, i, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0 || dropcnt !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_ovf: ovf=%b dc=%0d want 0 0", overflow, dropcnt);
        end
        tick(1'b1, 32'h108, 32'h99, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b1 || dropcnt !== 8'(m_dc) || count !== 4'd8) begin
            n_fail++;
            $display("FAIL clear_vs_drop: ovf=%b dc=%0d count=%0d want 1 %0d 8",
                     overflow, dropcnt, count, m_dc);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 32'h130 + i, 32'h50 + i, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 4'd0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b count=%0d data=%h want 0 0 0",
                     out_valid, count, out_data);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        tick(1'b1, 32'h100, 32'h77, 1'b0, 1'b0);
        n_checks++;
        if (count !== 4'd1 || out_data !== 32'h77 || out_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL post_reset_push: count=%0d data=%h addr=%h want 1 77 00",
                     count, out_data, out_addr);
        end
        idle(1'b1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_sole: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] adr;
        logic [39:0] eh;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: adr = 32'h100 | $urandom_range(0, 255);
                1: adr = 32'h100 | $urandom_range(0, 255);
                2: adr = $urandom;
                default: adr = 32'h200 | $urandom_range(0, 255);
            endcase
            tick($urandom_range(0, 3) != 0, adr, $urandom,
                 (i % 200) < 100 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15) == 0);
            eh = (mq.size() != 0) ? mq[0] : 40'h0;
            n_checks++;
            if (out_valid !== (mq.size() != 0) || count !== 4'(mq.size()) ||
                {out_addr, out_data} !== eh || overflow !== m_ovf ||
                dropcnt !== 8'(m_dc)) begin
                n_fail++;
                $display("FAIL random[%0d]: v=%b c=%0d head=%h_%h ovf=%b dc=%0d want v=%b c=%0d head=%h ovf=%b dc=%0d",
                         i, out_valid, count, out_addr, out_data, overflow, dropcnt,
                         mq.size() != 0, mq.size(), eh, m_ovf, m_dc);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_capture();
        test_window_filter();
        test_fill_overflow();
        test_full_push_pop();
        test_clear_priority();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/store_fifo_port.md
# store_fifo_port

Store-snooping output queue that sits downstream of the processor's data-memory port, beside `dmem`. It captures every store whose address falls in a memory-mapped window and queues `{address low byte, data}` in a FIFO. An external consumer drains the queue over a valid/ready handshake. It only snoops: it never stalls the processor and never blocks or alters the `dmem` write.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `BASE`, 32'h0000_0100: window base address.
- `MASK`, 32'hFFFF_FF00: a store hits when `(dataadr & MASK) == BASE`.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `memwrite` in 1: processor store strobe.
- `dataadr` in 32: store address (ALU result).
- `writedata` in 32: store data.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts head this cycle.
- `out_data` out 32: head entry data.
- `out_addr` out 8: head entry `dataadr[7:0]`.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; set when a hit store was dropped.
- `clear_ovf` in 1: synchronous clear of `overflow`.
- `dropcnt` out 8: saturating drop count (see Configuration).

## Operation
- push = `memwrite & ((dataadr & MASK) == BASE)`.
- pop = `out_valid & out_ready`.
- Storage: DEPTH x 40-bit array.
- Pointers: write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Occupancy: registered `count`.
- Full means `count == DEPTH`; empty means `count == 0`.
- Push when not full: write `{dataadr[7:0], writedata}` at `wp`, then increment `wp`.
- Push when full with no pop: the store is dropped.
  - `wp` and `count` do not change.
  - `overflow` is set to 1.
  - `dropcnt` increments, saturating at 255.
- Push when full with a pop in the same cycle: push is accepted and `count` stays at DEPTH. It is not a drop.
- Push and pop both happen with 0 < `count` < DEPTH: both pointers advance and `count` is unchanged.
- Pop when empty: impossible, because `out_valid` = 0.
- `out_valid` = (`count` != 0).
- `out_data` and `out_addr` present the entry at `rp` when valid, and read 0 when empty.
- Head stability: while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_addr` stay stable.
- `clear_ovf`: clears `overflow` on the next edge. If a drop happens in the same cycle, set wins and `overflow` = 1.
- Non-hit stores and cycles with `memwrite` = 0 leave the queue untouched.

## Timing
- Reset values, applied asynchronously:
  - `wp`, `rp`, `count` = 0.
  - `out_valid` = 0.
  - `out_data` = 0 and `out_addr` = 0.
  - `overflow` = 0.
  - `dropcnt` = 0.
- Array contents are not reset.
- Capture latency: a hit store sampled at edge N raises `out_valid` in the cycle after edge N when the queue was empty. There is no combinational path from `memwrite` to `out_valid`.
- Pop: the head is consumed at the edge where `out_valid & out_ready` is true. The next entry, or `out_valid` = 0, appears after that edge.
- `out_ready` may depend combinationally on `out_valid`. `out_valid` must not depend on `out_ready`.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation: all queued entries are discarded. `out_valid` falls immediately, independent of the clock.
- Pointer wrap: after DEPTH pushes, `wp` returns to 0 with no bubble.

## Configuration
- `STOREQ_DROPCNT_EN` defined:
  - `dropcnt` is an 8-bit register, cleared by reset and by `clear_ovf`.
  - It increments on each drop and saturates at 8'hFF.
  - On a same-cycle drop and `clear_ovf`, `dropcnt` loads 1.
- `STOREQ_DROPCNT_EN` undefined:
  - `dropcnt` is tied to 8'h00 and no counter logic is built.
  - `overflow` behaviour is unchanged.

## Test plan
- Single capture:
  - Stimulus: reset, then store 32'hDEADBEEF to 32'h104 with `out_ready` = 0.
  - Response: one cycle later `out_valid` = 1, `out_data` = 32'hDEADBEEF, `out_addr` = 8'h04, `count` = 1. All stay stable for 5 cycles.
- Window filter:
  - Stimulus: stores to 32'h54, 32'h200, 32'h0FC.
  - Response: `count` stays 0 and `out_valid` = 0.
  - Stimulus: a store to 32'h1FC.
  - Response: captured with `out_addr` = 8'hFC.
- Fill, overflow and drain:
  - Stimulus: with `out_ready` = 0, push values 1..10 (DEPTH = 8).
  - Response: `count` = 8, `overflow` = 1, `dropcnt` = 2 (macro on) or 0 (macro off).
  - Stimulus: drain with `out_ready` = 1.
  - Response: outputs 1..8 in order, then `out_valid` = 0.
- Simultaneous push and pop when full:
  - Stimulus: queue full, `out_ready` = 1, hit store of 32'hA5.
  - Response: `count` stays 8, no overflow, and 32'hA5 emerges last.
- Clear priority:
  - Stimulus: `clear_ovf` with no drop.
  - Response: `overflow` = 0 next cycle.
  - Stimulus: `clear_ovf` in the same cycle as a drop.
  - Response: `overflow` = 1, `dropcnt` = 1 (macro on).
- Asynchronous reset:
  - Stimulus: assert `reset` mid-cycle with 3 entries queued.
  - Response: `out_valid`, `count` and `out_data` go to 0 before the next edge.
  - Stimulus: push 32'h77 after release.
  - Response: it appears as the sole entry.
